// File: rtl/inc_counter_pkg.sv
// ---------------------------------------------------------------------------
// inc_counter_pkg
//
// Shared definitions for the registered incrementer / program counter.
//
// Contents:
//   action_t        2-bit per-cycle action code
//   ACT_HOLD        keep the current value
//   ACT_INC         advance by step
//   ACT_LOAD        capture load_val
//   ACT_CLR         clear to zero
//   resolve_action  priority resolution of clr > load > inc > hold
//
// The same resolve_action function is used by the decoder in the counter and
// by the reference model in the testbench, so the priority order has a single
// definition.
// ---------------------------------------------------------------------------
package inc_counter_pkg;

    typedef logic [1:0] action_t;

    localparam action_t ACT_HOLD = 2'd0;
    localparam action_t ACT_INC  = 2'd1;
    localparam action_t ACT_LOAD = 2'd2;
    localparam action_t ACT_CLR  = 2'd3;

    // Highest-priority request wins. Lower-priority requests raised in the
    // same cycle are simply dropped; nothing is queued for later.
    function automatic action_t resolve_action(input logic clr,
                                               input logic load,
                                               input logic inc);
        action_t act;
        if (clr) begin
            act = ACT_CLR;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (inc) begin
            act = ACT_INC;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/inc_counter_inc_n.sv
// ---------------------------------------------------------------------------
// inc_n
//
// Purely combinational WIDTH-bit unsigned adder with carry-out. This is the
// parametrised generalisation of the fixed +1 incrementer: instead of adding
// a constant one it adds an arbitrary step.
//
// Parameters:
//   WIDTH   operand width in bits
//
// Ports:
//   a       input  [WIDTH-1:0]  current counter value
//   b       input  [WIDTH-1:0]  increment amount
//   sum     output [WIDTH-1:0]  low WIDTH bits of a + b
//   carry   output              bit WIDTH of the (WIDTH+1)-bit sum
// ---------------------------------------------------------------------------
module inc_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Both operands are zero-extended by one bit so the carry falls out of
    // the top of the result rather than being lost.
    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/inc_counter.sv
// ---------------------------------------------------------------------------
// inc_counter
//
// Registered incrementer used as the program counter and general event
// counter in the CPU datapath. Each cycle one action is taken, in priority
// order: clear, load, step by a programmable amount, or hold.
//
// Parameters:
//   WIDTH     counter and data width in bits (>= 2)
//   SATURATE  0 = wrap modulo 2^WIDTH, 1 = clamp at all-ones
//
// Ports:
//   clk       input               rising-edge clock
//   rst_n     input               asynchronous active-low reset
//   clr       input               synchronous clear to zero
//   load      input               synchronous load of load_val
//   load_val  input  [WIDTH-1:0]  value captured on load
//   inc       input               advance by step
//   step      input  [WIDTH-1:0]  unsigned increment amount (0 = no change)
//   out       output [WIDTH-1:0]  registered counter value
//   wrap      output              registered pulse: last inc overflowed or
//                                 clamped
//   at_max    output              combinational, out is all-ones
// ---------------------------------------------------------------------------
module inc_counter
    import inc_counter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    action_t          action;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] inc_val;
    logic             inc_wrap;
    logic [WIDTH-1:0] next_out;
    logic             next_wrap;

    assign action = resolve_action(clr, load, inc);

    inc_n #(
        .WIDTH (WIDTH)
    ) u_inc_n (
        .a     (out),
        .b     (step),
        .sum   (sum),
        .carry (carry)
    );

    // In either mode a carry out of the adder is what raises wrap; only the
    // value written back differs. In saturate mode an overflowing step pins
    // the counter at all-ones, so repeated incs at the top keep pulsing wrap.
    generate
        if (SATURATE != 0) begin : g_saturate
            always_comb begin
                inc_val  = carry ? ALL_ONES : sum;
                inc_wrap = carry;
            end
        end else begin : g_wrap
            always_comb begin
                inc_val  = sum;
                inc_wrap = carry;
            end
        end
    endgenerate

    // wrap only reports the increment that just happened, so every action
    // other than an overflowing inc drives it back to zero.
    always_comb begin
        next_out  = out;
        next_wrap = 1'b0;
        case (action)
            ACT_CLR: begin
                next_out  = '0;
                next_wrap = 1'b0;
            end
            ACT_LOAD: begin
                next_out  = load_val;
                next_wrap = 1'b0;
            end
            ACT_INC: begin
                next_out  = inc_val;
                next_wrap = inc_wrap;
            end
            default: begin
                next_out  = out;
                next_wrap = 1'b0;
            end
        endcase
    end

    // Counter value and wrap flag. Reset clears both immediately, without
    // waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= '0;
            wrap <= 1'b0;
        end else begin
            out  <= next_out;
            wrap <= next_wrap;
        end
    end

    assign at_max = (out == ALL_ONES);

endmodule

// File: tb/tb_inc_counter.sv
// ---------------------------------------------------------------------------
// tb_inc_counter
//
// Testbench for inc_counter. Three instances are exercised:
//   dut_w   WIDTH=16, SATURATE=0
//   dut_s   WIDTH=16, SATURATE=1  (shares its inputs with dut_w)
//   dut_4   WIDTH=4,  SATURATE=0
// The 16-bit pair is driven from a table of hand-computed vectors. Reset
// mid-operation and the 4-bit wrap are hand-written sequences, followed by a
// random run of the 4-bit instance against a small reference model.
// ---------------------------------------------------------------------------
module tb_inc_counter;
    import inc_counter_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        clr;
    logic        load;
    logic        inc;
    logic [15:0] load_val;
    logic [15:0] step;
    logic [15:0] out_w;
    logic        wrap_w;
    logic        at_max_w;
    logic [15:0] out_s;
    logic        wrap_s;
    logic        at_max_s;

    logic        clr4;
    logic        load4;
    logic        inc4;
    logic [3:0]  load_val4;
    logic [3:0]  step4;
    logic [3:0]  out4;
    logic        wrap4;
    logic        at_max4;

    int checks;
    int failures;

    typedef struct {
        logic        clr;
        logic        load;
        logic        inc;
        logic [15:0] load_val;
        logic [15:0] step;
        logic [15:0] exp_out_w;
        logic        exp_wrap_w;
        logic [15:0] exp_out_s;
        logic        exp_wrap_s;
    } vec_t;

    vec_t vecs[$];

    inc_counter #(.WIDTH(16), .SATURATE(0)) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .inc      (inc),
        .step     (step),
        .out      (out_w),
        .wrap     (wrap_w),
        .at_max   (at_max_w)
    );

    inc_counter #(.WIDTH(16), .SATURATE(1)) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .inc      (inc),
        .step     (step),
        .out      (out_s),
        .wrap     (wrap_s),
        .at_max   (at_max_s)
    );

    inc_counter #(.WIDTH(4), .SATURATE(0)) dut_4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr4),
        .load     (load4),
        .load_val (load_val4),
        .inc      (inc4),
        .step     (step4),
        .out      (out4),
        .wrap     (wrap4),
        .at_max   (at_max4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, input logic l, input logic i,
                                input logic [15:0] lv, input logic [15:0] st,
                                input logic [15:0] ow, input logic ww,
                                input logic [15:0] os, input logic ws);
        vec_t v;
        v.clr        = c;
        v.load       = l;
        v.inc        = i;
        v.load_val   = lv;
        v.step       = st;
        v.exp_out_w  = ow;
        v.exp_wrap_w = ww;
        v.exp_out_s  = os;
        v.exp_wrap_s = ws;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic l, input logic i,
                                 input logic [15:0] lv, input logic [15:0] st);
        clr      = c;
        load     = l;
        inc      = i;
        load_val = lv;
        step     = st;
    endtask

    task automatic applyStimulus4(input logic c, input logic l, input logic i,
                                  input logic [3:0] lv, input logic [3:0] st);
        clr4      = c;
        load4     = l;
        inc4      = i;
        load_val4 = lv;
        step4     = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] m4;
        logic       w4;
        logic [4:0] s5;
        logic       rc, rl, ri;
        logic [3:0] rlv, rst4;
        action_t    act;

        checks   = 0;
        failures = 0;

        // Table: clr load inc load_val step | out_w wrap_w | out_s wrap_s
        vecs.push_back(mk(0, 1, 0, 16'h0003, 16'h0000, 16'h0003, 0, 16'h0003, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0004, 16'h0007, 0, 16'h0007, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 16'h0007, 0, 16'h0007, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0007, 0, 16'h0007, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0007, 0, 16'h0007, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0007, 0, 16'h0007, 0));
        vecs.push_back(mk(0, 1, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0001, 16'h0000, 1, 16'hFFFF, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'hFFFF, 0));
        vecs.push_back(mk(0, 1, 0, 16'hFFFE, 16'h0000, 16'hFFFE, 0, 16'hFFFE, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0003, 16'h0001, 1, 16'hFFFF, 1));
        vecs.push_back(mk(0, 1, 0, 16'hFFFD, 16'h0000, 16'hFFFD, 0, 16'hFFFD, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0001, 16'hFFFE, 0, 16'hFFFE, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0005, 16'h0003, 1, 16'hFFFF, 1));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0005, 16'h0008, 0, 16'hFFFF, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 0, 16'hFFFF, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0010, 16'h0000, 16'h0010, 0, 16'h0010, 0));
        vecs.push_back(mk(1, 1, 1, 16'h1234, 16'h0001, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 1, 16'h1234, 16'h0001, 16'h1234, 0, 16'h1234, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0001, 16'h1235, 0, 16'h1235, 0));
        vecs.push_back(mk(0, 1, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 16'hFFFF, 0, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'hFFFF, 16'hFFFE, 1, 16'hFFFF, 1));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0002, 16'h0000, 1, 16'hFFFF, 1));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0));

        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
        applyStimulus4(0, 0, 0, 4'h0, 4'h0);

        // Reset state, checked while reset is still asserted
        #12;
        checkOutput("reset_out_w", 32'(out_w), 32'h0);
        checkOutput("reset_wrap_w", 32'(wrap_w), 32'h0);
        checkOutput("reset_at_max_w", 32'(at_max_w), 32'h0);
        checkOutput("reset_out_s", 32'(out_s), 32'h0);
        checkOutput("reset_out_4", 32'(out4), 32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].clr, vecs[k].load, vecs[k].inc,
                          vecs[k].load_val, vecs[k].step);
            tick();
            checkOutput($sformatf("vec%0d_out_w", k), 32'(out_w), 32'(vecs[k].exp_out_w));
            checkOutput($sformatf("vec%0d_wrap_w", k), 32'(wrap_w), 32'(vecs[k].exp_wrap_w));
            checkOutput($sformatf("vec%0d_at_max_w", k), 32'(at_max_w),
                        32'(vecs[k].exp_out_w == 16'hFFFF));
            checkOutput($sformatf("vec%0d_out_s", k), 32'(out_s), 32'(vecs[k].exp_out_s));
            checkOutput($sformatf("vec%0d_wrap_s", k), 32'(wrap_s), 32'(vecs[k].exp_wrap_s));
            checkOutput($sformatf("vec%0d_at_max_s", k), 32'(at_max_s),
                        32'(vecs[k].exp_out_s == 16'hFFFF));
        end

        // Reset asserted between edges while an increment is requested
        applyStimulus(0, 1, 0, 16'h0004, 16'h0000);
        tick();
        applyStimulus(0, 0, 1, 16'h0000, 16'h0001);
        tick();
        checkOutput("pre_reset_out_w", 32'(out_w), 32'h5);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out_w", 32'(out_w), 32'h0);
        checkOutput("async_reset_wrap_w", 32'(wrap_w), 32'h0);
        checkOutput("async_reset_at_max_w", 32'(at_max_w), 32'h0);
        checkOutput("async_reset_out_s", 32'(out_s), 32'h0);
        tick();
        checkOutput("held_reset_out_w", 32'(out_w), 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_inc_out_w", 32'(out_w), 32'h1);
        checkOutput("post_reset_inc_wrap_w", 32'(wrap_w), 32'h0);
        applyStimulus(0, 0, 0, 16'h0000, 16'h0000);

        // 4-bit wrap
        applyStimulus4(0, 1, 0, 4'hE, 4'h0);
        tick();
        checkOutput("w4_load_out", 32'(out4), 32'hE);
        applyStimulus4(0, 0, 1, 4'h0, 4'h3);
        tick();
        checkOutput("w4_wrap_out", 32'(out4), 32'h1);
        checkOutput("w4_wrap_flag", 32'(wrap4), 32'h1);
        checkOutput("w4_wrap_at_max", 32'(at_max4), 32'h0);

        // 4-bit random run against the reference model
        m4 = 4'h1;
        w4 = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            rc   = ($urandom_range(15, 0) == 0);
            rl   = ($urandom_range(7, 0) == 0);
            ri   = ($urandom_range(3, 0) != 0);
            rlv  = 4'($urandom_range(15, 0));
            rst4 = 4'($urandom_range(15, 0));
            applyStimulus4(rc, rl, ri, rlv, rst4);
            act = resolve_action(rc, rl, ri);
            w4  = 1'b0;
            case (act)
                ACT_CLR:  m4 = 4'h0;
                ACT_LOAD: m4 = rlv;
                ACT_INC: begin
                    s5 = {1'b0, m4} + {1'b0, rst4};
                    m4 = s5[3:0];
                    w4 = s5[4];
                end
                default: m4 = m4;
            endcase
            tick();
            checkOutput($sformatf("rand%0d_out_wrap_max", n),
                        32'({out4, wrap4, at_max4}),
                        32'({m4, w4, (m4 == 4'hF)}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
